// File: rtl/next_hop_select_if.sv
// Bundles the controller handshake, the neighbour-table read port and the result
// outputs of next_hop_select; clock and reset stay outside as plain ports.
interface next_hop_select_if #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
);
    logic                  en;
    logic                  start;
    logic [WORD_WIDTH-1:0] MY_NODE_ID;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [5:0]            neighborCount;
    logic [WORD_WIDTH-1:0] mem_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic [WORD_WIDTH-1:0] destinationID;
    logic [WORD_WIDTH-1:0] bestQ;
    logic                  noValidDest;
    logic                  done;

    modport master (
        output en, start, MY_NODE_ID, base_addr, neighborCount, mem_data,
        input  mem_addr, mem_rd, destinationID, bestQ, noValidDest, done
    );

    modport slave (
        input  en, start, MY_NODE_ID, base_addr, neighborCount, mem_data,
        output mem_addr, mem_rd, destinationID, bestQ, noValidDest, done
    );
endinterface

// File: rtl/next_hop_select.sv
// Scans the neighbour table and selects the neighbour with the highest Q-value.
// Optional macro NEXT_HOP_SKIP_SELF_EN: entries whose ID is this node or 16'hFFFF are skipped.
module next_hop_select #(
    parameter int WORD_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 11,
    parameter int MAX_NEIGHBORS = 32
) (
    input  logic              clock,
    input  logic              rst,
    next_hop_select_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        RD_ID = 3'd2,
        RD_Q  = 3'd3,
        CMP   = 3'd4
    } state_t;

    localparam logic [5:0]            MAX_N    = 6'(MAX_NEIGHBORS);
    localparam logic [WORD_WIDTH-1:0] ALL_ONES = {WORD_WIDTH{1'b1}};
`ifdef NEXT_HOP_SKIP_SELF_EN
    localparam logic                  SKIP_SELF = 1'b1;
`else
    localparam logic                  SKIP_SELF = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [WORD_WIDTH-1:0] my_id_q, my_id_d;
    logic [5:0]            n_q, n_d;
    logic [5:0]            idx_q, idx_d;
    logic [WORD_WIDTH-1:0] id_q, id_d;
    logic                  have_q, have_d;
    logic [WORD_WIDTH-1:0] cand_id_q, cand_id_d;
    logic [WORD_WIDTH-1:0] cand_val_q, cand_val_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [WORD_WIDTH-1:0] dest_q, dest_d;
    logic [WORD_WIDTH-1:0] best_q, best_d;
    logic                  no_valid_q, no_valid_d;
    logic                  done_q, done_d;
    logic [5:0]            n_eff_s;
    logic                  eligible_s;

    // Next-state and next-output computation for the scan controller.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        my_id_d    = my_id_q;
        n_d        = n_q;
        idx_d      = idx_q;
        id_d       = id_q;
        have_d     = have_q;
        cand_id_d  = cand_id_q;
        cand_val_d = cand_val_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        dest_d     = dest_q;
        best_d     = best_q;
        no_valid_d = no_valid_q;
        done_d     = done_q;

        if (bus.neighborCount > MAX_N) begin
            n_eff_s = MAX_N;
        end else begin
            n_eff_s = bus.neighborCount;
        end
        eligible_s = !SKIP_SELF || ((id_q != my_id_q) && (id_q != ALL_ONES));

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    done_d     = 1'b0;
                    no_valid_d = 1'b0;
                    dest_d     = {WORD_WIDTH{1'b0}};
                    best_d     = {WORD_WIDTH{1'b0}};
                    state_d    = WAIT;
                end else begin
                    state_d    = IDLE;
                end
            end
            WAIT: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    my_id_d = bus.MY_NODE_ID;
                    n_d     = n_eff_s;
                    if (n_eff_s == 6'd0) begin
                        no_valid_d = 1'b1;
                        dest_d     = ALL_ONES;
                        best_d     = {WORD_WIDTH{1'b0}};
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        idx_d      = 6'd0;
                        have_d     = 1'b0;
                        cand_id_d  = {WORD_WIDTH{1'b0}};
                        cand_val_d = {WORD_WIDTH{1'b0}};
                        state_d    = RD_ID;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            RD_ID: begin
                mem_addr_d = base_q + ADDR_WIDTH'({idx_q, 1'b0});
                mem_rd_d   = 1'b1;
                state_d    = RD_Q;
            end
            RD_Q: begin
                id_d       = bus.mem_data;
                mem_addr_d = base_q + ADDR_WIDTH'({idx_q, 1'b1});
                mem_rd_d   = 1'b1;
                state_d    = CMP;
            end
            CMP: begin
                mem_rd_d = 1'b0;
                // Strictly-greater keeps the earliest entry on equal Q-values.
                if (eligible_s && (!have_q || (bus.mem_data > cand_val_q))) begin
                    have_d     = 1'b1;
                    cand_id_d  = id_q;
                    cand_val_d = bus.mem_data;
                end else begin
                    have_d     = have_q;
                end
                idx_d = idx_q + 6'd1;
                if (idx_d == n_q) begin
                    if (have_d) begin
                        dest_d     = cand_id_d;
                        best_d     = cand_val_d;
                        no_valid_d = 1'b0;
                    end else begin
                        dest_d     = ALL_ONES;
                        best_d     = {WORD_WIDTH{1'b0}};
                        no_valid_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RD_ID;
                end
            end
            default: begin
                mem_rd_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any scan in progress.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= {ADDR_WIDTH{1'b0}};
            my_id_q    <= {WORD_WIDTH{1'b0}};
            n_q        <= 6'd0;
            idx_q      <= 6'd0;
            id_q       <= {WORD_WIDTH{1'b0}};
            have_q     <= 1'b0;
            cand_id_q  <= {WORD_WIDTH{1'b0}};
            cand_val_q <= {WORD_WIDTH{1'b0}};
            mem_addr_q <= {ADDR_WIDTH{1'b0}};
            mem_rd_q   <= 1'b0;
            dest_q     <= {WORD_WIDTH{1'b0}};
            best_q     <= {WORD_WIDTH{1'b0}};
            no_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            my_id_q    <= my_id_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            id_q       <= id_d;
            have_q     <= have_d;
            cand_id_q  <= cand_id_d;
            cand_val_q <= cand_val_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            dest_q     <= dest_d;
            best_q     <= best_d;
            no_valid_q <= no_valid_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_rd        = mem_rd_q;
    assign bus.destinationID = dest_q;
    assign bus.bestQ         = best_q;
    assign bus.noValidDest   = no_valid_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_next_hop_select.sv
// Directed bench for next_hop_select with a combinational table model behind the
// registered read address.
module tb_next_hop_select;
    logic clock;
    logic rst;
    int unsigned pass_cnt;
    int unsigned total_cnt;
    logic [15:0] mem [0:2047];

    next_hop_select_if #(.WORD_WIDTH(16), .ADDR_WIDTH(11)) bus_if ();

    next_hop_select #(.WORD_WIDTH(16), .ADDR_WIDTH(11), .MAX_NEIGHBORS(32)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_if)
    );

    assign bus_if.mem_data = bus_if.mem_rd ? mem[bus_if.mem_addr] : 16'h0000;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setup(input logic [15:0] my_id, input logic [10:0] base, input logic [5:0] cnt);
        bus_if.MY_NODE_ID    = my_id;
        bus_if.base_addr     = base;
        bus_if.neighborCount = cnt;
    endtask

    // Leaves the bench #1 after the edge that samples start.
    task automatic arm_start();
        bus_if.en = 1'b1;
        tick();
        bus_if.en    = 1'b0;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({bus_if.done, bus_if.noValidDest, bus_if.mem_rd, bus_if.mem_addr, bus_if.destinationID, bus_if.bestQ} !== 46'd0) begin
            $display("FAIL reset_state: got done=%0b nv=%0b rd=%0b addr=%0h dest=%0h q=%0h want all 0",
                     bus_if.done, bus_if.noValidDest, bus_if.mem_rd, bus_if.mem_addr, bus_if.destinationID, bus_if.bestQ);
        end else pass_cnt++;
        rst = 1'b0;
        tick();
        setup(16'd1, 11'd100, 6'd3);
        arm_start();
        tick();
        tick();
        total_cnt++;
        if (bus_if.mem_rd !== 1'b1 || bus_if.mem_addr !== 11'd101) begin
            $display("FAIL reset_pre_cmp: got rd=%0b addr=%0d want rd=1 addr=101", bus_if.mem_rd, bus_if.mem_addr);
        end else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus_if.done, bus_if.noValidDest, bus_if.mem_rd, bus_if.mem_addr, bus_if.destinationID, bus_if.bestQ} !== 46'd0) begin
            $display("FAIL reset_mid_scan: got rd=%0b addr=%0h done=%0b want all 0", bus_if.mem_rd, bus_if.mem_addr, bus_if.done);
        end else pass_cnt++;
        @(negedge clock);
        rst = 1'b0;
        bus_if.start = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (bus_if.mem_rd !== 1'b0 || bus_if.done !== 1'b0) begin
            $display("FAIL reset_idle_start: got rd=%0b done=%0b want 0 0", bus_if.mem_rd, bus_if.done);
        end else pass_cnt++;
        bus_if.start = 1'b0;
        arm_start();
        repeat (8) tick();
        total_cnt++;
        if (bus_if.done !== 1'b0) begin
            $display("FAIL rescan_early: got done=%0b want 0", bus_if.done);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (bus_if.done !== 1'b1 || bus_if.destinationID !== 16'd7 || bus_if.bestQ !== 16'd40) begin
            $display("FAIL rescan_result: got done=%0b dest=%0d q=%0d want 1 7 40", bus_if.done, bus_if.destinationID, bus_if.bestQ);
        end else pass_cnt++;
    endtask

    task automatic test_max_select();
        setup(16'd1, 11'd100, 6'd3);
        bus_if.en = 1'b1;
        tick();
        bus_if.en = 1'b0;
        total_cnt++;
        if (bus_if.done !== 1'b0 || bus_if.destinationID !== 16'd0 || bus_if.bestQ !== 16'd0) begin
            $display("FAIL en_clears: got done=%0b dest=%0d q=%0d want 0 0 0", bus_if.done, bus_if.destinationID, bus_if.bestQ);
        end else pass_cnt++;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            total_cnt++;
            if (bus_if.mem_rd !== 1'b1 || bus_if.mem_addr !== 11'(100 + 2 * j)) begin
                $display("FAIL addr_id_%0d: got rd=%0b addr=%0d want rd=1 addr=%0d", j, bus_if.mem_rd, bus_if.mem_addr, 100 + 2 * j);
            end else pass_cnt++;
            tick();
            total_cnt++;
            if (bus_if.mem_rd !== 1'b1 || bus_if.mem_addr !== 11'(101 + 2 * j)) begin
                $display("FAIL addr_q_%0d: got rd=%0b addr=%0d want rd=1 addr=%0d", j, bus_if.mem_rd, bus_if.mem_addr, 101 + 2 * j);
            end else pass_cnt++;
            tick();
            total_cnt++;
            if (bus_if.mem_rd !== 1'b0 || bus_if.done !== (j == 2)) begin
                $display("FAIL cmp_%0d: got rd=%0b done=%0b want rd=0 done=%0b", j, bus_if.mem_rd, bus_if.done, j == 2);
            end else pass_cnt++;
        end
        total_cnt++;
        if (bus_if.destinationID !== 16'd7 || bus_if.bestQ !== 16'd40 || bus_if.noValidDest !== 1'b0) begin
            $display("FAIL max_result: got dest=%0d q=%0d nv=%0b want 7 40 0", bus_if.destinationID, bus_if.bestQ, bus_if.noValidDest);
        end else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (bus_if.done !== 1'b1 || bus_if.destinationID !== 16'd7) begin
            $display("FAIL result_held: got done=%0b dest=%0d want 1 7", bus_if.done, bus_if.destinationID);
        end else pass_cnt++;
    endtask

    task automatic test_tie_wrap();
        setup(16'd1, 11'd2047, 6'd2);
        arm_start();
        tick();
        total_cnt++;
        if (bus_if.mem_addr !== 11'd2047) begin
            $display("FAIL wrap_a0: got addr=%0d want 2047", bus_if.mem_addr);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (bus_if.mem_addr !== 11'd0) begin
            $display("FAIL wrap_a1: got addr=%0d want 0", bus_if.mem_addr);
        end else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (bus_if.mem_addr !== 11'd1) begin
            $display("FAIL wrap_a2: got addr=%0d want 1", bus_if.mem_addr);
        end else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (bus_if.done !== 1'b1 || bus_if.destinationID !== 16'd4 || bus_if.bestQ !== 16'd30) begin
            $display("FAIL tie_result: got done=%0b dest=%0d q=%0d want 1 4 30", bus_if.done, bus_if.destinationID, bus_if.bestQ);
        end else pass_cnt++;
    endtask

    task automatic test_zero_count();
        setup(16'd1, 11'd500, 6'd0);
        arm_start();
        total_cnt++;
        if (bus_if.done !== 1'b1 || bus_if.noValidDest !== 1'b1 || bus_if.destinationID !== 16'hFFFF ||
            bus_if.bestQ !== 16'd0 || bus_if.mem_rd !== 1'b0) begin
            $display("FAIL zero_result: got done=%0b nv=%0b dest=%0h q=%0d rd=%0b want 1 1 ffff 0 0",
                     bus_if.done, bus_if.noValidDest, bus_if.destinationID, bus_if.bestQ, bus_if.mem_rd);
        end else pass_cnt++;
        bus_if.start = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            total_cnt++;
            if (bus_if.mem_rd !== 1'b0 || bus_if.done !== 1'b1) begin
                $display("FAIL idle_start_%0d: got rd=%0b done=%0b want 0 1", j, bus_if.mem_rd, bus_if.done);
            end else pass_cnt++;
        end
        bus_if.start = 1'b0;
    endtask

    task automatic test_skip_self();
        setup(16'd7, 11'd300, 6'd2);
        arm_start();
        repeat (6) tick();
`ifdef NEXT_HOP_SKIP_SELF_EN
        total_cnt++;
        if (bus_if.done !== 1'b1 || bus_if.destinationID !== 16'd3 || bus_if.bestQ !== 16'd20) begin
            $display("FAIL self_pair: got done=%0b dest=%0d q=%0d want 1 3 20", bus_if.done, bus_if.destinationID, bus_if.bestQ);
        end else pass_cnt++;
`else
        total_cnt++;
        if (bus_if.done !== 1'b1 || bus_if.destinationID !== 16'd7 || bus_if.bestQ !== 16'd90) begin
            $display("FAIL self_pair: got done=%0b dest=%0d q=%0d want 1 7 90", bus_if.done, bus_if.destinationID, bus_if.bestQ);
        end else pass_cnt++;
`endif
        setup(16'd7, 11'd400, 6'd1);
        arm_start();
        repeat (3) tick();
`ifdef NEXT_HOP_SKIP_SELF_EN
        total_cnt++;
        if (bus_if.done !== 1'b1 || bus_if.noValidDest !== 1'b1 || bus_if.destinationID !== 16'hFFFF || bus_if.bestQ !== 16'd0) begin
            $display("FAIL self_only: got done=%0b nv=%0b dest=%0h q=%0d want 1 1 ffff 0",
                     bus_if.done, bus_if.noValidDest, bus_if.destinationID, bus_if.bestQ);
        end else pass_cnt++;
`else
        total_cnt++;
        if (bus_if.done !== 1'b1 || bus_if.noValidDest !== 1'b0 || bus_if.destinationID !== 16'd7 || bus_if.bestQ !== 16'd50) begin
            $display("FAIL self_only: got done=%0b nv=%0b dest=%0d q=%0d want 1 0 7 50",
                     bus_if.done, bus_if.noValidDest, bus_if.destinationID, bus_if.bestQ);
        end else pass_cnt++;
`endif
    endtask

    task automatic test_clamp();
        setup(16'd0, 11'd200, 6'd40);
        arm_start();
        repeat (40) tick();
        bus_if.en = 1'b1;
        tick();
        bus_if.en = 1'b0;
        repeat (54) tick();
        total_cnt++;
        if (bus_if.done !== 1'b0) begin
            $display("FAIL clamp_early: got done=%0b want 0 at edge k+95", bus_if.done);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (bus_if.done !== 1'b1 || bus_if.destinationID !== 16'd120 || bus_if.bestQ !== 16'd1000) begin
            $display("FAIL clamp_result: got done=%0b dest=%0d q=%0d want 1 120 1000", bus_if.done, bus_if.destinationID, bus_if.bestQ);
        end else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst                  = 1'b1;
        bus_if.en            = 1'b0;
        bus_if.start         = 1'b0;
        bus_if.MY_NODE_ID    = 16'd0;
        bus_if.base_addr     = 11'd0;
        bus_if.neighborCount = 6'd0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'd0;
        mem[100] = 16'd5;  mem[101] = 16'd10;
        mem[102] = 16'd7;  mem[103] = 16'd40;
        mem[104] = 16'd9;  mem[105] = 16'd25;
        mem[2047] = 16'd4; mem[0] = 16'd30;
        mem[1] = 16'd6;    mem[2] = 16'd30;
        mem[300] = 16'd7;  mem[301] = 16'd90;
        mem[302] = 16'd3;  mem[303] = 16'd20;
        mem[400] = 16'd7;  mem[401] = 16'd50;
        for (int i = 0; i < 40; i++) begin
            mem[200 + 2 * i] = 16'(100 + i);
            mem[201 + 2 * i] = (i < 32) ? 16'(i) : 16'd2000;
        end
        mem[241] = 16'd1000;

        test_reset();
        test_max_select();
        test_tie_wrap();
        test_zero_count();
        test_skip_self();
        test_clamp();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
